uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among four byte requesters, such as the switch/button path, a loopback echo of received bytes, and status reporters. It grants one requester at a time and latches that requester's byte onto the transmitter data bus. It drives the transmitter's transmit strobe, then holds off further grants for one full frame time, because the transmitter exposes no busy flag. Sits between the requesters and transmitter.transmit/data in the top level.

---
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among four byte requesters.
// Grants one requester, strobes the transmitter, then waits out a full frame before the next grant.
module uart_tx_arbiter #(
    parameter int START_CLKS = 2,
    parameter int FRAME_CLKS = 104170,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CLKS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CLKS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       winner;
    logic [3:0]       ready_nxt;
    logic             start_nxt;
    logic             done_nxt;
    logic [7:0]       data_nxt;
    logic [1:0]       gid_nxt;

    // First pending requester found scanning upward from the pointer, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = from + 2'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req_valid, ptr);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        ready_nxt = 4'b0000;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        data_nxt  = tx_data;
        gid_nxt   = grant_id;
        case (state)
            IDLE: begin
                if (req_valid != 4'b0000) begin
                    data_nxt  = req_data[{winner, 3'b000} +: 8];
                    gid_nxt   = winner;
                    ready_nxt = 4'b0001 << winner;
                    ptr_nxt   = winner + 2'd1;
                    cnt_nxt   = '0;
                    start_nxt = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == START_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    start_nxt = 1'b1;
                end
            end
            WAIT: begin
                // No busy flag from the transmitter, so the frame time is counted out here.
                if (cnt == FRAME_LAST) begin
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= 2'd0;
            req_ready <= 4'b0000;
            tx_start  <= 1'b0;
            tx_done   <= 1'b0;
            tx_data   <= 8'h00;
            grant_id  <= 2'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ptr       <= ptr_nxt;
            req_ready <= ready_nxt;
            tx_start  <= start_nxt;
            tx_done   <= done_nxt;
            tx_data   <= data_nxt;
            grant_id  <= gid_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a timing model built on grant times predicts every output each cycle,
// with directed scenarios followed by randomized requester traffic.
module tb_uart_tx_arbiter;

    localparam int S   = 2;
    localparam int F   = 20;
    localparam int GAP = 1 + S + F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int pushes = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .START_CLKS(S),
        .FRAME_CLKS(F),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .grant_id(grant_id),
        .busy(busy),
        .tx_done(tx_done)
    );

    // Requester byte FIFOs (ring of 16 per requester)
    logic [7:0] fifo [4][16];
    int head [4];
    int tail [4];

    // Grant log observed from the DUT handshake
    int         log_id [$];
    logic [7:0] log_byte [$];
    int         log_cyc [$];

    // Reference model: only the time of the last grant, the winner and the pointer
    longint     cyc = 0;
    longint     g_edge = -100000;
    int         m_ptr = 0;
    logic [1:0] m_gid = 2'd0;
    logic [7:0] m_data = 8'h00;

    function automatic int rr_pick(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            g_edge <= -100000;
            m_ptr  <= 0;
            m_gid  <= 2'd0;
            m_data <= 8'h00;
        end else if (cyc - g_edge > S + F && req_valid != 4'b0000) begin
            g_edge <= cyc;
            m_gid  <= 2'(rr_pick(req_valid, m_ptr));
            m_ptr  <= (rr_pick(req_valid, m_ptr) + 1) % 4;
            m_data <= 8'(req_data >> (8 * rr_pick(req_valid, m_ptr)));
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    function automatic int cnt_of(int i);
        return tail[i] - head[i];
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = (cnt_of(i) > 0);
            req_data[8*i +: 8]  = (cnt_of(i) > 0) ? fifo[i][head[i] % 16] : 8'h00;
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fifo[i][tail[i] % 16] = b;
        tail[i]++;
        pushes++;
        drive();
    endtask

    task automatic cycle();
        longint     d;
        logic [3:0] e_ready;
        @(negedge clk);
        ncyc++;
        d       = cyc - 1 - g_edge;
        e_ready = (d == 0) ? (4'b0001 << m_gid) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("tx_start", 32'(tx_start), 32'(d < S));
        chk("busy", 32'(busy), 32'(d < S + F));
        chk("tx_done", 32'(tx_done), 32'(d == S + F));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        if (req_ready != 4'b0000) begin
            log_id.push_back(int'(grant_id));
            log_byte.push_back(tx_data);
            log_cyc.push_back(ncyc);
        end
        for (int i = 0; i < 4; i++)
            if (req_ready[i] && cnt_of(i) > 0) head[i]++;
        drive();
    endtask

    task automatic wait_grants(input int n);
        int target;
        target = log_id.size() + n;
        for (int k = 0; k < (n + 1) * GAP + 10; k++) begin
            if (log_id.size() >= target) break;
            cycle();
        end
        chk("grant_timeout", 32'(log_id.size() >= target), 32'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3 * GAP; k++) begin
            if (cyc - 1 - g_edge > S + F) break;
            cycle();
        end
    endtask

    task automatic wait_done(output int low_cycles);
        bit seen;
        seen       = 1'b0;
        low_cycles = 0;
        for (int k = 0; k < 2 * GAP; k++) begin
            cycle();
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            if (!tx_start) low_cycles++;
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int b;
        int rel;
        int nlow;
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Reset held with all requesters pending
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i));
        repeat (3) cycle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        rel   = ncyc;

        // Round-robin over all four
        b = log_id.size();
        wait_grants(4);
        if (log_id.size() >= b + 4) begin
            chk("first_latency", 32'(log_cyc[b] - rel), 32'd1);
            for (int k = 0; k < 4; k++) begin
                chk("rr_id", 32'(log_id[b+k]), 32'(k));
                chk("rr_byte", 32'(log_byte[b+k]), 32'(8'h10 + k));
                if (k > 0) chk("rr_gap", 32'(log_cyc[b+k] - log_cyc[b+k-1]), 32'(GAP));
            end
        end

        // Single request and frame timing
        wait_idle();
        b = log_id.size();
        push(2, 8'hA5);
        wait_grants(1);
        if (log_id.size() > b) begin
            chk("single_id", 32'(log_id[b]), 32'd2);
            chk("single_byte", 32'(log_byte[b]), 32'hA5);
        end
        wait_done(nlow);
        chk("done_after_start_fall", 32'(nlow), 32'(F));

        // Pointer skip: grant 1, then 0 and 1 together
        wait_idle();
        b = log_id.size();
        push(1, 8'h31);
        wait_grants(1);
        push(0, 8'h40);
        push(1, 8'h41);
        wait_grants(2);
        if (log_id.size() >= b + 3) begin
            chk("skip_id0", 32'(log_id[b]), 32'd1);
            chk("skip_id1", 32'(log_id[b+1]), 32'd0);
            chk("skip_id2", 32'(log_id[b+2]), 32'd1);
            chk("skip_byte1", 32'(log_byte[b+1]), 32'h40);
            chk("skip_byte2", 32'(log_byte[b+2]), 32'h41);
        end

        // Back-to-back: re-request in the tx_done cycle
        wait_idle();
        b = log_id.size();
        push(3, 8'h53);
        wait_grants(1);
        wait_done(nlow);
        push(3, 8'h54);
        wait_grants(1);
        if (log_id.size() >= b + 2) begin
            chk("b2b_gap", 32'(log_cyc[b+1] - log_cyc[b]), 32'(GAP));
            chk("b2b_id", 32'(log_id[b+1]), 32'd3);
            chk("b2b_byte", 32'(log_byte[b+1]), 32'h54);
        end

        // Mid-frame reset: pointer returns to 0
        wait_idle();
        b = log_id.size();
        push(1, 8'h61);
        wait_grants(1);
        repeat (5) cycle();
        push(1, 8'h62);
        push(3, 8'h63);
        reset = 1'b0;
        cycle();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_start", 32'(tx_start), 32'd0);
        chk("mrst_done", 32'(tx_done), 32'd0);
        reset = 1'b1;
        wait_grants(2);
        if (log_id.size() >= b + 3) begin
            chk("mrst_id", 32'(log_id[b+1]), 32'd1);
            chk("mrst_byte", 32'(log_byte[b+1]), 32'h62);
            chk("mrst_next_id", 32'(log_id[b+2]), 32'd3);
        end

        // Random traffic with occasional resets
        repeat (1500) begin
            cycle();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0 && cnt_of(i) < 3) push(i, 8'($urandom));
            reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
        end
        reset = 1'b1;
        for (int k = 0; k < 16 * GAP; k++) begin
            if (cnt_of(0) + cnt_of(1) + cnt_of(2) + cnt_of(3) == 0) break;
            cycle();
        end
        chk("drain", 32'(cnt_of(0) + cnt_of(1) + cnt_of(2) + cnt_of(3)), 32'd0);
        chk("byte_count", 32'(log_id.size()), 32'(pushes));
        repeat (GAP) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
